// File: rtl/mem_ctrl_sram_if.sv
// Request/response bus between a memory-controller master and the SRAM controller.
// The master issues req/addr/write/wData/wStrb and receives ready/resp/rData.
interface mem_ctrl_sram_if #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32
);
    logic                   req;
    logic                   ready;
    logic [AddrWidth-1:0]   addr;
    logic                   write;
    logic [DataWidth-1:0]   wData;
    logic [DataWidth/8-1:0] wStrb;
    logic [1:0]             resp;
    logic [DataWidth-1:0]   rData;

    modport master (
        output req, addr, write, wData, wStrb,
        input  ready, resp, rData
    );

    modport slave (
        input  req, addr, write, wData, wStrb,
        output ready, resp, rData
    );
endinterface

// File: rtl/mem_ctrl_sram.sv
// Single-port SRAM controller: req/ready handshake, byte strobes, fixed wait states,
// base-address window with ERROR response for misaligned or out-of-window accesses.
module mem_ctrl_sram #(
    parameter int                   DataWidth  = 32,
    parameter int                   AddrWidth  = 32,
    parameter int                   Depth      = 1024,
    parameter logic [AddrWidth-1:0] BaseAddr   = '0,
    parameter int                   WaitStates = 0
) (
    input  logic          clk,
    input  logic          nReset,
    mem_ctrl_sram_if.slave bus
);

    localparam int NB = DataWidth / 8;
    localparam int LB = $clog2(NB);
    localparam int IW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CW = (WaitStates > 0) ? $clog2(WaitStates + 1) : 1;

    localparam logic [AddrWidth-1:0] ALIGN_MASK = AddrWidth'(NB - 1);
    localparam logic [AddrWidth:0]   DEPTH_LIM  = (AddrWidth + 1)'(Depth);
    localparam logic [CW-1:0]        CNT_LOAD   = CW'((WaitStates > 0) ? WaitStates - 1 : 0);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]           state_reg, state_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic                 write_reg;
    logic                 err_reg;
    logic [IW-1:0]        idx_reg;
    logic [DataWidth-1:0] wdata_reg;
    logic [NB-1:0]        wstrb_reg;

    logic                 accept;
    logic [AddrWidth-1:0] in_off;
    logic [AddrWidth-1:0] in_word;
    logic [IW-1:0]        in_idx;
    logic                 in_err;

    logic                 commit_we;
    logic                 rd_en;
    logic                 rd_write;
    logic                 rd_err;
    logic [IW-1:0]        rd_idx;
    logic [DataWidth-1:0] rd_word;

    assign bus.ready = (state_reg != WAIT);
    assign accept    = bus.req && bus.ready;

    always_comb begin
        in_off  = bus.addr - BaseAddr;
        in_word = in_off >> LB;
        in_idx  = in_word[IW-1:0];
        in_err  = (bus.addr < BaseAddr)
               || ({1'b0, in_word} >= DEPTH_LIM)
               || ((bus.addr & ALIGN_MASK) != '0);
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: begin
                if (accept) begin
                    if (WaitStates == 0) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_LOAD;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            write_reg <= 1'b0;
            err_reg   <= 1'b0;
            idx_reg   <= '0;
            wdata_reg <= '0;
            wstrb_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                write_reg <= bus.write;
                err_reg   <= in_err;
                idx_reg   <= in_idx;
                wdata_reg <= bus.wData;
                wstrb_reg <= bus.wStrb;
            end
        end
    end

    // The write commits on the edge that ends RESP; an async reset drops out of
    // RESP before that edge, so an aborted transfer never reaches the array.
    assign commit_we = (state_reg == RESP) && write_reg && !err_reg;

    // The array is read on the edge entering RESP, from the latched transfer when
    // leaving WAIT or straight from the bus when accepting with no wait states.
    assign rd_write = (state_reg == WAIT) ? write_reg : bus.write;
    assign rd_err   = (state_reg == WAIT) ? err_reg   : in_err;
    assign rd_idx   = (state_reg == WAIT) ? idx_reg   : in_idx;
    assign rd_en    = (state_next == RESP) && !rd_write && !rd_err;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] lane_mem [Depth];
            logic [7:0] rd_reg;

            // A read accepted during a write's RESP sees the byte being committed.
            always_ff @(posedge clk) begin
                if (commit_we && wstrb_reg[gi]) begin
                    lane_mem[idx_reg] <= wdata_reg[gi*8 +: 8];
                end
                if (rd_en) begin
                    if (commit_we && wstrb_reg[gi] && (idx_reg == rd_idx)) begin
                        rd_reg <= wdata_reg[gi*8 +: 8];
                    end else begin
                        rd_reg <= lane_mem[rd_idx];
                    end
                end
            end

            assign rd_word[gi*8 +: 8] = rd_reg;
        end
    endgenerate

    assign bus.resp  = (state_reg != RESP) ? 2'b00 :
                       (err_reg ? 2'b10 : 2'b01);
    assign bus.rData = ((state_reg == RESP) && !write_reg && !err_reg) ? rd_word : '0;

endmodule

// File: tb/tb_mem_ctrl_sram.sv
// Directed bench for mem_ctrl_sram: three instances covering zero wait states,
// three and four wait states, and a non-zero base-address window.
module tb_mem_ctrl_sram;

    logic clk = 1'b0;
    logic nReset;

    always #5 clk = ~clk;

    logic        req_v   [3];
    logic        write_v [3];
    logic [31:0] addr_v  [3];
    logic [31:0] wdata_v [3];
    logic [3:0]  wstrb_v [3];
    logic        ready_v [3];
    logic [1:0]  resp_v  [3];
    logic [31:0] rdata_v [3];

    int checks = 0;
    int errors = 0;

    mem_ctrl_sram_if #(.DataWidth(32), .AddrWidth(32)) b0 ();
    mem_ctrl_sram_if #(.DataWidth(32), .AddrWidth(32)) b1 ();
    mem_ctrl_sram_if #(.DataWidth(32), .AddrWidth(32)) b2 ();

    assign b0.req   = req_v[0];   assign b1.req   = req_v[1];   assign b2.req   = req_v[2];
    assign b0.write = write_v[0]; assign b1.write = write_v[1]; assign b2.write = write_v[2];
    assign b0.addr  = addr_v[0];  assign b1.addr  = addr_v[1];  assign b2.addr  = addr_v[2];
    assign b0.wData = wdata_v[0]; assign b1.wData = wdata_v[1]; assign b2.wData = wdata_v[2];
    assign b0.wStrb = wstrb_v[0]; assign b1.wStrb = wstrb_v[1]; assign b2.wStrb = wstrb_v[2];
    assign ready_v[0] = b0.ready; assign ready_v[1] = b1.ready; assign ready_v[2] = b2.ready;
    assign resp_v[0]  = b0.resp;  assign resp_v[1]  = b1.resp;  assign resp_v[2]  = b2.resp;
    assign rdata_v[0] = b0.rData; assign rdata_v[1] = b1.rData; assign rdata_v[2] = b2.rData;

    mem_ctrl_sram #(.DataWidth(32), .AddrWidth(32), .Depth(1024),
                    .BaseAddr(32'h0), .WaitStates(0))
        u0 (.clk(clk), .nReset(nReset), .bus(b0));
    mem_ctrl_sram #(.DataWidth(32), .AddrWidth(32), .Depth(1024),
                    .BaseAddr(32'h0), .WaitStates(3))
        u1 (.clk(clk), .nReset(nReset), .bus(b1));
    mem_ctrl_sram #(.DataWidth(32), .AddrWidth(32), .Depth(16),
                    .BaseAddr(32'h100), .WaitStates(4))
        u2 (.clk(clk), .nReset(nReset), .bus(b2));

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Single transfer on instance d with w wait states; called and returning at a negedge.
    task automatic do_xfer(input int d, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] st, input int w,
                           input logic [1:0] er, input logic [31:0] ed, input string nm);
        checks++;
        if (ready_v[d] !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_accept got %b want 1", nm, ready_v[d]);
        end
        req_v[d] = 1'b1; write_v[d] = wr; addr_v[d] = a; wdata_v[d] = wd; wstrb_v[d] = st;
        @(negedge clk);
        req_v[d] = 1'b0; write_v[d] = 1'b0; addr_v[d] = 32'h0; wdata_v[d] = 32'h0; wstrb_v[d] = 4'h0;
        for (int i = 0; i < w; i++) begin
            checks++;
            if (ready_v[d] !== 1'b0 || resp_v[d] !== 2'b00) begin
                errors++;
                $display("FAIL %s wait_cycle%0d ready=%b resp=%b want ready=0 resp=00",
                         nm, i, ready_v[d], resp_v[d]);
            end
            @(negedge clk);
        end
        checks++;
        if (resp_v[d] !== er) begin
            errors++;
            $display("FAIL %s resp got %b want %b", nm, resp_v[d], er);
        end
        checks++;
        if (rdata_v[d] !== ed) begin
            errors++;
            $display("FAIL %s rdata got %h want %h", nm, rdata_v[d], ed);
        end
        checks++;
        if (ready_v[d] !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_in_resp got %b want 1", nm, ready_v[d]);
        end
        $display("xfer %-14s dut=%0d %s addr=%h wdata=%h strb=%b resp=%b rdata=%h",
                 nm, d, wr ? "WR" : "RD", a, wd, st, resp_v[d], rdata_v[d]);
        @(negedge clk);
        checks++;
        if (resp_v[d] !== 2'b00) begin
            errors++;
            $display("FAIL %s resp_after got %b want 00", nm, resp_v[d]);
        end
    endtask

    task automatic test_reset;
        nReset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            req_v[d] = 1'b0; write_v[d] = 1'b0; addr_v[d] = 32'h0;
            wdata_v[d] = 32'h0; wstrb_v[d] = 4'h0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ready_v[d] !== 1'b1 || resp_v[d] !== 2'b00 || rdata_v[d] !== 32'h0) begin
                errors++;
                $display("FAIL reset dut%0d ready=%b resp=%b rdata=%h want 1/00/0",
                         d, ready_v[d], resp_v[d], rdata_v[d]);
            end
            $display("xfer reset         dut=%0d ready=%b resp=%b rdata=%h",
                     d, ready_v[d], resp_v[d], rdata_v[d]);
        end
        nReset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        do_xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 2'b01, 32'h0,        "t1_write");
        do_xfer(0, 1'b0, 32'h10, 32'h0,        4'h0, 0, 2'b01, 32'hDEADBEEF, "t1_read");
    endtask

    task automatic test_wait_states;
        do_xfer(1, 1'b1, 32'h8, 32'h0BADF00D, 4'hF, 3, 2'b01, 32'h0,        "t2_write");
        do_xfer(1, 1'b0, 32'h8, 32'h0,        4'h0, 3, 2'b01, 32'h0BADF00D, "t2_read");
    endtask

    task automatic test_strobes;
        do_xfer(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, 2'b01, 32'h0,        "t3_full");
        do_xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 0, 2'b01, 32'h0,        "t3_strb0101");
        do_xfer(0, 1'b0, 32'h20, 32'h0,        4'h0, 0, 2'b01, 32'h11BB33DD, "t3_readback");
        do_xfer(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, 2'b01, 32'h0,        "t3_strb0000");
        do_xfer(0, 1'b0, 32'h20, 32'h0,        4'h0, 0, 2'b01, 32'h11BB33DD, "t3_unchanged");
    endtask

    task automatic test_errors;
        do_xfer(0, 1'b0, 32'h2,    32'h0,        4'h0, 0, 2'b10, 32'h0,        "t4_rd_misal");
        do_xfer(0, 1'b1, 32'h12,   32'h55555555, 4'hF, 0, 2'b10, 32'h0,        "t4_wr_misal");
        do_xfer(0, 1'b0, 32'h1000, 32'h0,        4'h0, 0, 2'b10, 32'h0,        "t4_rd_depth");
        do_xfer(0, 1'b0, 32'h10,   32'h0,        4'h0, 0, 2'b01, 32'hDEADBEEF, "t4_rd_intact");
        do_xfer(2, 1'b1, 32'h13C,  32'h5A5A5A5A, 4'hF, 4, 2'b01, 32'h0,        "t4_wr_last");
        do_xfer(2, 1'b0, 32'h140,  32'h0,        4'h0, 4, 2'b10, 32'h0,        "t4_rd_depth");
        do_xfer(2, 1'b1, 32'hFC,   32'hFFFFFFFF, 4'hF, 4, 2'b10, 32'h0,        "t4_wr_below");
        do_xfer(2, 1'b0, 32'h102,  32'h0,        4'h0, 4, 2'b10, 32'h0,        "t4_rd_misal");
        do_xfer(2, 1'b0, 32'h13C,  32'h0,        4'h0, 4, 2'b01, 32'h5A5A5A5A, "t4_rd_intact");
    endtask

    task automatic test_back_to_back;
        logic        op_wr   [4];
        logic [31:0] op_addr [4];
        logic [31:0] op_data [4];
        logic [31:0] exp_rd  [4];
        op_wr[0] = 1'b1; op_addr[0] = 32'h40; op_data[0] = 32'hA5A50001; exp_rd[0] = 32'h0;
        op_wr[1] = 1'b0; op_addr[1] = 32'h40; op_data[1] = 32'h0;        exp_rd[1] = 32'hA5A50001;
        op_wr[2] = 1'b1; op_addr[2] = 32'h44; op_data[2] = 32'h5A5A0002; exp_rd[2] = 32'h0;
        op_wr[3] = 1'b0; op_addr[3] = 32'h44; op_data[3] = 32'h0;        exp_rd[3] = 32'h5A5A0002;
        // Prior contents differ, so a stale read cannot match.
        do_xfer(0, 1'b1, 32'h40, 32'h01020304, 4'hF, 0, 2'b01, 32'h0, "t5_pre_a");
        do_xfer(0, 1'b1, 32'h44, 32'h05060708, 4'hF, 0, 2'b01, 32'h0, "t5_pre_b");
        for (int i = 0; i < 4; i++) begin
            req_v[0] = 1'b1; write_v[0] = op_wr[i]; addr_v[0] = op_addr[i];
            wdata_v[0] = op_data[i]; wstrb_v[0] = 4'hF;
            @(negedge clk);
            checks++;
            if (resp_v[0] !== 2'b01 || ready_v[0] !== 1'b1) begin
                errors++;
                $display("FAIL t5_op%0d resp=%b ready=%b want 01/1", i, resp_v[0], ready_v[0]);
            end
            checks++;
            if (rdata_v[0] !== exp_rd[i]) begin
                errors++;
                $display("FAIL t5_op%0d rdata got %h want %h", i, rdata_v[0], exp_rd[i]);
            end
            $display("xfer t5_op%0d        dut=0 %s addr=%h wdata=%h resp=%b rdata=%h",
                     i, op_wr[i] ? "WR" : "RD", op_addr[i], op_data[i], resp_v[0], rdata_v[0]);
        end
        req_v[0] = 1'b0; write_v[0] = 1'b0; wstrb_v[0] = 4'h0;
        @(negedge clk);
        checks++;
        if (resp_v[0] !== 2'b00) begin
            errors++;
            $display("FAIL t5_idle resp got %b want 00", resp_v[0]);
        end
    endtask

    task automatic test_reset_abort;
        logic bad;
        do_xfer(2, 1'b1, 32'h104, 32'h12345678, 4'hF, 4, 2'b01, 32'h0, "t6_setup");
        req_v[2] = 1'b1; write_v[2] = 1'b1; addr_v[2] = 32'h104;
        wdata_v[2] = 32'hCAFEF00D; wstrb_v[2] = 4'hF;
        @(negedge clk);
        req_v[2] = 1'b0; write_v[2] = 1'b0; wdata_v[2] = 32'h0; wstrb_v[2] = 4'h0;
        @(negedge clk);
        checks++;
        if (ready_v[2] !== 1'b0) begin
            errors++;
            $display("FAIL t6_in_wait ready got %b want 0", ready_v[2]);
        end
        #2 nReset = 1'b0;
        #1;
        checks++;
        if (ready_v[2] !== 1'b1 || resp_v[2] !== 2'b00) begin
            errors++;
            $display("FAIL t6_async ready=%b resp=%b want 1/00", ready_v[2], resp_v[2]);
        end
        @(negedge clk);
        nReset = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (resp_v[2] !== 2'b00 || ready_v[2] !== 1'b1) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL t6_no_resp a response or busy cycle appeared after abort, want none");
        end
        $display("xfer t6_abort       dut=2 WR addr=00000104 aborted by reset");
        do_xfer(2, 1'b0, 32'h104, 32'h0,        4'h0, 4, 2'b01, 32'h12345678, "t6_unchanged");
        do_xfer(2, 1'b1, 32'h108, 32'h89ABCDEF, 4'hF, 4, 2'b01, 32'h0,        "t6_next_wr");
        do_xfer(2, 1'b0, 32'h108, 32'h0,        4'h0, 4, 2'b01, 32'h89ABCDEF, "t6_next_rd");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_states();
        test_strobes();
        test_errors();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
